// File: rtl/dcache_wt.sv
// -----------------------------------------------------------------------------
// dcache_wt -- direct-mapped, write-through, no-write-allocate L1 data cache.
//
// Sits between the pipeline memory stage (responder side, req_*/resp_*) and a
// slower backing memory reached over a valid/ready bus (initiator side, mem_*).
// One-word lines. Load hits answer on the following cycle without stalling.
// Load misses and all stores hold `stall` high until the backing transaction
// completes, then return a single-cycle resp_valid pulse.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req_valid       core request present
//   req_we          1 = store, 0 = load
//   req_addr        byte address
//   req_wdata       store data, LSB-aligned
//   req_funct3      RV32I load/store funct3 (size and sign)
//   stall           core must hold the request and freeze
//   resp_valid      load data valid / store complete (one-cycle pulse)
//   resp_rdata      size/sign-extended load result (0 for stores)
//   mem_req_valid   backing request present
//   mem_req_ready   backing accepts the request
//   mem_req_we      backing write
//   mem_req_addr    word-aligned backing address
//   mem_req_wdata   lane-aligned store data
//   mem_req_be      byte enables
//   mem_resp_valid  backing read data valid
//   mem_resp_rdata  backing read word
//
// Optional feature (macro DCACHE_STATS_EN):
//   hit_count, miss_count  saturating 32-bit load hit / load miss counters.
//
// Lane and byte-enable logic assumes a 32-bit data path (4 byte lanes).
// -----------------------------------------------------------------------------
module dcache_wt #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = DATA_WIDTH - INDEX_BITS - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  stall,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [DATA_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  output logic [3:0]            mem_req_be,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [2:0] {
    IDLE,
    MISS_REQ,
    MISS_WAIT,
    WR_REQ,
    RESP
  } state_t;

  // ---------------------------------------------------------------------------
  // Size / lane helpers
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_WIDTH-1:0] load_ext(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            off,
    input logic [2:0]            f3
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_ext = {{(DATA_WIDTH-8){b[7]}}, b};
      3'b001:  load_ext = {{(DATA_WIDTH-16){h[15]}}, h};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, b};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, h};
      default: load_ext = word;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] off, input logic [2:0] f3);
    case (f3)
      3'b000:  store_be = 4'b0001 << off;
      3'b001:  store_be = off[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data into every lane so the byte enables alone
  // select which bytes land.
  function automatic logic [DATA_WIDTH-1:0] store_lanes(
    input logic [DATA_WIDTH-1:0] wd,
    input logic [2:0]            f3
  );
    case (f3)
      3'b000:  store_lanes = {4{wd[7:0]}};
      3'b001:  store_lanes = {2{wd[15:0]}};
      default: store_lanes = wd;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] lanes,
    input logic [3:0]            be
  );
    merge_bytes = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merge_bytes[8*i +: 8] = lanes[8*i +: 8];
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  state_t                  state;
  logic [LINES-1:0]        valid_q;
  logic [TAG_BITS-1:0]     tag_mem  [LINES];
  logic [DATA_WIDTH-1:0]   data_mem [LINES];

  // Captured request, used by every non-IDLE state.
  logic                    cap_we;
  logic [DATA_WIDTH-1:0]   cap_addr;
  logic [DATA_WIDTH-1:0]   cap_wdata;
  logic [2:0]              cap_funct3;

  // ---------------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------------
  logic [INDEX_BITS-1:0]   req_index;
  logic [TAG_BITS-1:0]     req_tag;
  logic [INDEX_BITS-1:0]   cap_index;
  logic [TAG_BITS-1:0]     cap_tag;
  logic                    hit;
  logic                    fill_en;
  logic                    store_hit_en;
  logic [DATA_WIDTH-1:0]   merged_word;

  assign req_index = req_addr[INDEX_BITS+1:2];
  assign req_tag   = req_addr[DATA_WIDTH-1:INDEX_BITS+2];
  assign cap_index = cap_addr[INDEX_BITS+1:2];
  assign cap_tag   = cap_addr[DATA_WIDTH-1:INDEX_BITS+2];
  assign hit       = valid_q[req_index] && (tag_mem[req_index] == req_tag);

  // A late mem_resp_valid outside MISS_WAIT must never touch the arrays.
  assign fill_en      = (state == MISS_WAIT) && mem_resp_valid;
  assign store_hit_en = (state == IDLE) && req_valid && req_we && hit;
  assign merged_word  = merge_bytes(data_mem[req_index],
                                    store_lanes(req_wdata, req_funct3),
                                    store_be(req_addr[1:0], req_funct3));

  // NOTE: tag/data arrays carry no reset -- the valid bits alone decide
  // whether their contents mean anything, and a reset here would prevent RAM
  // inference.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_mem[cap_index] <= mem_resp_rdata;
      tag_mem[cap_index]  <= cap_tag;
    end else if (store_hit_en) begin
      data_mem[req_index] <= merged_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus-facing outputs decoded from the registered state
  // ---------------------------------------------------------------------------
  // NOTE: every output gets a default before the case so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    stall         = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_be    = 4'b0000;
    mem_req_addr  = {cap_addr[DATA_WIDTH-1:2], 2'b00};
    mem_req_wdata = store_lanes(cap_wdata, cap_funct3);
    case (state)
      // Reset forces IDLE; gating with rst keeps stall low even if the core
      // is still presenting a request while reset is asserted.
      IDLE:      stall = !rst && req_valid && (req_we || !hit);
      MISS_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_be    = 4'b1111;
      end
      MISS_WAIT: stall = 1'b1;
      WR_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_be    = store_be(cap_addr[1:0], cap_funct3);
      end
      default:   stall = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM, valid bits, response and statistics registers
  // ---------------------------------------------------------------------------
  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      valid_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      cap_we     <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_funct3 <= 3'b000;
`ifdef DCACHE_STATS_EN
      hit_count  <= '0;
      miss_count <= '0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_we || !hit) begin
              cap_we     <= req_we;
              cap_addr   <= req_addr;
              cap_wdata  <= req_wdata;
              cap_funct3 <= req_funct3;
              state      <= req_we ? WR_REQ : MISS_REQ;
`ifdef DCACHE_STATS_EN
              if (!req_we && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
`endif
            end else begin
              resp_valid <= 1'b1;
              resp_rdata <= load_ext(data_mem[req_index], req_addr[1:0], req_funct3);
`ifdef DCACHE_STATS_EN
              if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
`endif
            end
          end
        end
        MISS_REQ: begin
          if (mem_req_ready) state <= MISS_WAIT;
        end
        MISS_WAIT: begin
          if (mem_resp_valid) begin
            valid_q[cap_index] <= 1'b1;
            resp_valid         <= 1'b1;
            resp_rdata         <= load_ext(mem_resp_rdata, cap_addr[1:0], cap_funct3);
            state              <= RESP;
          end
        end
        WR_REQ: begin
          if (mem_req_ready) begin
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            state      <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // cap_we is kept for debug visibility of the in-flight request type.
  logic unused_cap_we;
  assign unused_cap_we = cap_we;

endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate L1 data cache between the pipeline memory stage and a slower backing data memory.
- Acts as responder to the core's load/store requests and as initiator on a valid/ready backing-memory bus.
- Hits return in one cycle with no stall. Misses and stores assert `stall` until the backing transaction completes.

Parameters:
- DATA_WIDTH, 32, data and address width.
- INDEX_BITS, 6, log2 of line count (64 one-word lines).
- TAG_BITS, DATA_WIDTH-INDEX_BITS-2, stored tag width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  core request present
- req_we  in  1  1=store, 0=load
- req_addr  in  DATA_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, LSB-aligned
- req_funct3  in  3  access size/sign (RV32I load/store funct3)
- stall  out  1  core must hold request and freeze pipeline
- resp_valid  out  1  load data valid / store complete (1-cycle pulse)
- resp_rdata  out  DATA_WIDTH  extended load result
- mem_req_valid  out  1  backing request
- mem_req_ready  in  1  backing accepts request
- mem_req_we  out  1  backing write
- mem_req_addr  out  DATA_WIDTH  word-aligned address (low 2 bits 0)
- mem_req_wdata  out  DATA_WIDTH  lane-aligned store data
- mem_req_be  out  4  byte enables
- mem_resp_valid  in  1  backing read data valid
- mem_resp_rdata  in  DATA_WIDTH  backing read word

Behaviour:
- Address decomposition:
  - index = addr[INDEX_BITS+1:2]; tag = addr[DATA_WIDTH-1:INDEX_BITS+2].
  - Arrays: valid bit (flops), tag, data word.
- Reset (async):
  - state=IDLE; all valid bits 0.
  - stall, resp_valid, mem_req_valid, mem_req_we = 0; mem_req_be=0; resp_rdata=0.
  - Applies mid-transaction: the in-flight backing request is abandoned.
- States: IDLE, MISS_REQ, MISS_WAIT, WR_REQ, RESP.
- IDLE, req_valid=0: no action.
- IDLE, load hit (valid & tag match):
  - stall=0; request not captured.
  - Next cycle: resp_valid=1, resp_rdata=extended word; state stays IDLE.
  - Back-to-back hits sustain 1 per cycle.
- IDLE, load miss:
  - stall=1 combinationally; capture request; ->MISS_REQ.
- IDLE, store (hit or miss):
  - stall=1; capture request; ->WR_REQ.
  - On hit, merge enabled bytes into the data word on this edge.
  - On miss, array unchanged.
- MISS_REQ:
  - mem_req_valid=1, we=0, be=4'b1111; stall=1.
  - On mem_req_ready ->MISS_WAIT.
  - Ready in the first cycle of valid is legal.
- MISS_WAIT:
  - stall=1; wait for mem_resp_valid.
  - On response: write tag/data, set valid, register extended resp_rdata; ->RESP.
- WR_REQ:
  - mem_req_valid=1, we=1, lane-shifted wdata/be; stall=1.
  - On mem_req_ready ->RESP.
- RESP:
  - resp_valid=1, stall=0; req_* ignored this cycle (core advances); ->IDLE.
- Outputs held stable while mem_req_valid=1 and ready=0.
- Non-IDLE states ignore req_* and use the captured copy.
- Backing memory never asserts mem_resp_valid outside MISS_WAIT. If it does, the response is ignored.
- Size/extension:
  - funct3 000 LB/SB: lane addr[1:0], be=0001<<addr[1:0].
  - 001 LH/SH: lane addr[1], be=0011<<(2*addr[1]); addr[0] ignored.
  - 010 LW/SW: be=1111; addr[1:0] ignored.
  - 100 LBU, 101 LHU: zero-extend; 000/001 loads sign-extend.
  - Other funct3: treated as word.
- Store data is replicated/shifted into lanes: SB wdata[7:0] to every byte lane, SH wdata[15:0] to both halves.
- resp_rdata for stores is 0.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- With macro defined:
  - Adds outputs hit_count, miss_count (32-bit each).
  - Load hit increments hit_count in IDLE; load miss increments miss_count on entry to MISS_REQ.
  - Stores are not counted. Counters saturate at 0xFFFFFFFF; reset to 0.
- Without macro: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then LW 0x100 with backing word 0xDEADBEEF and ready/resp 2 cycles late:
  - stall high through MISS_WAIT.
  - RESP cycle: resp_valid=1, rdata=0xDEADBEEF.
  - Repeat LW 0x100: hit, stall=0, rdata next cycle.
- After the fill, LB 0x103 -> 0xFFFFFFDE; LBU 0x103 -> 0x000000DE; LH 0x102 -> 0xFFFFDEAD; LHU 0x100 -> 0x0000BEEF.
- SB 0x101 wdata 0x12 on the cached line:
  - mem_req_we=1, be=0010, addr=0x100, wdata=0x12121212.
  - Subsequent LW 0x100 hits -> 0xDEAD12EF.
- SW 0x200 (miss) 0x55:
  - Write-through only.
  - Next LW 0x200 misses (no allocate) and fetches from backing memory.
- Conflict: LW 0x100 then LW 0x100+(1<<8) (same index, different tag) -> both miss; third LW 0x100 misses again.
- Assert rst during MISS_WAIT:
  - mem_req_valid=0, stall=0 immediately.
  - Prior-hit address LW 0x100 misses after reset.
  - With DCACHE_STATS_EN: counts 0.
